star_collect: RTL
=================

STAR_COLLECT -- requirements
Module: star_collect

Interface
REQ-001 Parameter POWER_FRAMES, default 300, SHALL set total star-power duration in frames (>WARN_FRAMES, <=1023).
REQ-002 Parameter WARN_FRAMES, default 60, SHALL set the length of the final blinking window in frames.
REQ-003 Parameter BLINK_BIT, default 2, SHALL select the frame-timer bit driving blink (toggle every 2^BLINK_BIT frames).
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 touch_star  in  4  one-cycle touch pulses from up to four star instances (gated by their enable).
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 game_over  in  1  level; freezes collection and cancels power.
REQ-009 snd_ack  in  1  sound-block acknowledge.
REQ-010 score_tens  out  4  BCD tens of stars collected.
REQ-011 score_ones  out  4  BCD ones of stars collected.
REQ-012 invincible  out  1  high while star power active.
REQ-013 char_visible  out  1  character draw enable (blink).
REQ-014 snd_req  out  1  star-pickup sound request.

Function
REQ-015 Every cycle with game_over=0, the collected total SHALL increase by popcount(touch_star) (0..4), saturating at 99.
REQ-016 Score outputs SHALL be registered and update one cycle after the touch cycle.
REQ-017 FSM states IDLE, POWER, WARN SHALL be used; reset state IDLE.
REQ-018 IDLE: on any touch bit (game_over=0), load frame timer with POWER_FRAMES and enter POWER next cycle.
REQ-019 POWER/WARN: timer SHALL decrement by 1 on each frame_tick; other cycles it holds.
REQ-020 POWER -> WARN when the decrement makes the timer equal WARN_FRAMES; WARN -> IDLE when the decrement makes it 0.
REQ-021 Touch in POWER or WARN SHALL reload POWER_FRAMES and enter POWER; touch and frame_tick in the same cycle: reload wins.
REQ-022 invincible SHALL be 1 in POWER and WARN, 0 in IDLE, registered from state (same cycle as state).
REQ-023 char_visible SHALL be 1 in IDLE and POWER; in WARN it SHALL equal NOT timer[BLINK_BIT].
REQ-024 snd_req SHALL rise the cycle after a touch cycle and hold until snd_ack sampled high, then fall the following cycle.
REQ-025 Touches while snd_req high SHALL coalesce (no extra request); a touch in the same cycle snd_ack is seen SHALL keep snd_req high for one more request.
REQ-026 game_over=1 SHALL force IDLE and timer 0 next cycle, ignore touch_star, hold score, and leave an in-flight snd_req handshake to complete.

Reset
REQ-027 RST SHALL set: state IDLE, timer 0, total 0, score_tens 0, score_ones 0, invincible 0, char_visible 1, snd_req 0.
REQ-028 RST asserted mid-power SHALL take priority over every input in that cycle; outputs reach reset values on the next edge.

Structure
REQ-029 Package star_pkg SHALL hold the state enum, default POWER_FRAMES/WARN_FRAMES and SCORE_MAX=99.
REQ-030 Binary-to-BCD conversion of the 7-bit total SHALL live in sub-module star_bcd (combinational, 0..99), outputs registered in star_collect.

Verification
REQ-031 Reset, single touch_star=0001 -> next cycle score 0/1, invincible=1, snd_req=1; snd_ack held -> snd_req 0 the cycle after.
REQ-032 touch_star=1111 at total 97 -> score 9/9 (saturated), not wrap.
REQ-033 Touch then 240 frame_ticks -> WARN entered, invincible=1; char_visible toggles every 4 ticks; 60 more ticks -> IDLE, invincible=0, char_visible=1.
REQ-034 Touch at frame 250 of power (in WARN) coinciding with frame_tick -> POWER, timer 300, char_visible=1.
REQ-035 game_over=1 during POWER with touch_star=0010 -> next cycle IDLE, invincible=0, score unchanged.
REQ-036 RST pulse during WARN with touch active -> all outputs at REQ-027 values, no score increment.

Source files
------------

// File: rtl/star_pkg.sv
// Shared types and constants for the star-collection block.
package star_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POWER = 2'd1,
        ST_WARN  = 2'd2
    } star_state_e;

    localparam int         DEF_POWER_FRAMES = 300;
    localparam int         DEF_WARN_FRAMES  = 60;
    localparam logic [6:0] SCORE_MAX        = 7'd99;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/star_bcd.sv
// Combinational binary-to-BCD for a 0..99 total; larger inputs clamp to 99.
module star_bcd
    import star_pkg::*;
(
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] clamp_s;
    logic [6:0] tens_full_s;
    logic [6:0] ones_full_s;

    // Clamp and split into decimal digits.
    always_comb begin
        clamp_s     = (bin > SCORE_MAX) ? SCORE_MAX : bin;
        tens_full_s = clamp_s / 7'd10;
        ones_full_s = clamp_s % 7'd10;
        tens        = tens_full_s[3:0];
        ones        = ones_full_s[3:0];
    end

endmodule

// File: rtl/star_collect.sv
// Star pickup scoring, star-power timer with end-of-power blink, and pickup
// sound handshake.
module star_collect
    import star_pkg::*;
#(
    parameter int POWER_FRAMES = DEF_POWER_FRAMES,
    parameter int WARN_FRAMES  = DEF_WARN_FRAMES,
    parameter int BLINK_BIT    = 2
) (
    input  logic       sys_clk,
    input  logic       RST,
    input  logic [3:0] touch_star,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic       snd_ack,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic       invincible,
    output logic       char_visible,
    output logic       snd_req
);

    localparam logic [9:0] POWER_LOAD = 10'(POWER_FRAMES);
    localparam logic [9:0] WARN_LOAD  = 10'(WARN_FRAMES);

    star_state_e state_r, state_next_s;
    logic [9:0]  timer_r, timer_next_s, timer_dec_s;
    logic [6:0]  total_r, total_next_s, total_sum_s;
    logic        touch_any_s;
    logic        snd_req_next_s;
    logic [3:0]  tens_s, ones_s;
    logic        invincible_r, char_visible_r, snd_req_r;
    logic [3:0]  score_tens_r, score_ones_r;

    // Score accumulation with saturation; frozen while game_over.
    always_comb begin
        touch_any_s = (|touch_star) & ~game_over;
        total_sum_s = total_r + {4'b0000, popcount4(touch_star)};
        if (game_over) begin
            total_next_s = total_r;
        end else if (total_sum_s > SCORE_MAX) begin
            total_next_s = SCORE_MAX;
        end else begin
            total_next_s = total_sum_s;
        end
    end

    // Converting the next total lets the score registers land one cycle after the touch.
    star_bcd u_bcd (
        .bin  (total_next_s),
        .tens (tens_s),
        .ones (ones_s)
    );

    // Power FSM next-state and timer; a touch reload beats a same-cycle frame tick.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        timer_dec_s  = timer_r - 10'd1;
        if (game_over) begin
            state_next_s = ST_IDLE;
            timer_next_s = 10'd0;
        end else if (touch_any_s) begin
            state_next_s = ST_POWER;
            timer_next_s = POWER_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_POWER: begin
                    if (frame_tick) begin
                        timer_next_s = timer_dec_s;
                        if (timer_dec_s == WARN_LOAD) begin
                            state_next_s = ST_WARN;
                        end else begin
                            state_next_s = ST_POWER;
                        end
                    end else begin
                        state_next_s = ST_POWER;
                    end
                end
                ST_WARN: begin
                    if (frame_tick) begin
                        timer_next_s = timer_dec_s;
                        if (timer_dec_s == 10'd0) begin
                            state_next_s = ST_IDLE;
                        end else begin
                            state_next_s = ST_WARN;
                        end
                    end else begin
                        state_next_s = ST_WARN;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    timer_next_s = 10'd0;
                end
            endcase
        end
    end

    // Sound request: new touches set it, ack clears it unless a touch arrives alongside.
    always_comb begin
        if (touch_any_s) begin
            snd_req_next_s = 1'b1;
        end else if (snd_req_r && snd_ack) begin
            snd_req_next_s = 1'b0;
        end else begin
            snd_req_next_s = snd_req_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (RST) begin
            state_r        <= ST_IDLE;
            timer_r        <= 10'd0;
            total_r        <= 7'd0;
            score_tens_r   <= 4'd0;
            score_ones_r   <= 4'd0;
            invincible_r   <= 1'b0;
            char_visible_r <= 1'b1;
            snd_req_r      <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            timer_r        <= timer_next_s;
            total_r        <= total_next_s;
            score_tens_r   <= tens_s;
            score_ones_r   <= ones_s;
            invincible_r   <= (state_next_s != ST_IDLE);
            char_visible_r <= (state_next_s == ST_WARN) ? ~timer_next_s[BLINK_BIT] : 1'b1;
            snd_req_r      <= snd_req_next_s;
        end
    end

    assign score_tens   = score_tens_r;
    assign score_ones   = score_ones_r;
    assign invincible   = invincible_r;
    assign char_visible = char_visible_r;
    assign snd_req      = snd_req_r;

endmodule
